// File: rtl/tile_state_pkg.sv
// Shared definitions for the tile state RAM.
// Contents:
//   - board geometry (TILE_COLS, TILE_ROWS)
//   - bit positions of the packed tile word:
//       SPR1  [20:10]
//       SPR2  [31:21]
//       FLAGS [9:0]
//   - command opcode enum (cmd_op_e)
//   - writer FSM state enum (state_e)
//   - merge_field: replaces one field of a tile word
// The renderer imports the same field constants, so the field layout lives here only.
package tile_state_pkg;

  localparam int TILE_COLS = 26;
  localparam int TILE_ROWS = 16;

  localparam int SPR1_LSB  = 10;
  localparam int SPR1_MSB  = 20;
  localparam int SPR2_LSB  = 21;
  localparam int SPR2_MSB  = 31;
  localparam int FLAGS_LSB = 0;
  localparam int FLAGS_MSB = 9;

  typedef enum logic [1:0] {
    OP_SET_SPR1  = 2'b00,
    OP_SET_SPR2  = 2'b01,
    OP_SET_FLAGS = 2'b10,
    OP_CLEAR     = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_MOD  = 3'd2,
    ST_WR   = 3'd3,
    ST_CLR  = 3'd4
  } state_e;

  // Returns word with only the field selected by op replaced.
  // The flags field is 10 bits wide, so data[10] is ignored for OP_SET_FLAGS.
  function automatic logic [31:0] merge_field(input cmd_op_e     op,
                                              input logic [31:0] word,
                                              input logic [10:0] data);
    logic [31:0] r;
    r = word;
    case (op)
      OP_SET_SPR1:  r[SPR1_MSB:SPR1_LSB]   = data;
      OP_SET_SPR2:  r[SPR2_MSB:SPR2_LSB]   = data;
      OP_SET_FLAGS: r[FLAGS_MSB:FLAGS_LSB] = data[9:0];
      default:      r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tile_addr_calc.sv
// Combinational tile coordinate to RAM address mapping.
// Also used by the game-logic collision lookups.
// Ports:
//   x_i        tile column
//   y_i        tile row
//   addr_o     y*COLS + x, truncated to 10 bits
//   in_range_o 1 when x < COLS and y < ROWS
module tile_addr_calc #(
  parameter int COLS = 26,
  parameter int ROWS = 16
) (
  input  logic [4:0] x_i,
  input  logic [4:0] y_i,
  output logic [9:0] addr_o,
  output logic       in_range_o
);

  assign addr_o     = ({5'd0, y_i} * 10'(COLS)) + {5'd0, x_i};
  assign in_range_o = (32'(x_i) < 32'(COLS)) && (32'(y_i) < 32'(ROWS));

endmodule

// File: rtl/tile_state_writer.sv
// Write-side engine for the tile state RAM; it owns the RAM's write port.
//
// Operations:
//   - Field update: a read-modify-write of one tile word. The selected field is
//     replaced and the other fields are preserved.
//   - Clear: sweeps all COLS*ROWS words to CLEAR_WORD.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
//   - cmd_ready is high only in IDLE, so commands are strictly serialised.
//   - cmd_* must stay stable while cmd_valid is high and cmd_ready is low.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_op               00 sprite1, 01 sprite2, 10 flags, 11 clear board
//   cmd_x, cmd_y         tile coordinates (not range-checked for clear)
//   cmd_data             new field value
//   ram_addr/ram_wdata/ram_we/ram_rdata
//                        state RAM port; read data arrives one cycle after the address
//   done                 one-cycle pulse when a command retires
//   err                  one-cycle pulse when an out-of-range command is dropped
//   dbg_state_o          current FSM state
//
// Build option TILE_STATE_WRITER_INIT_CLEAR_EN:
//   - defined: leaving reset runs a full clear sweep before the first command is taken;
//   - undefined: leaving reset goes straight to IDLE and the RAM is left as preloaded.
module tile_state_writer
  import tile_state_pkg::*;
#(
  parameter int          COLS       = TILE_COLS,
  parameter int          ROWS       = TILE_ROWS,
  parameter logic [31:0] CLEAR_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_x,
  input  logic [4:0]  cmd_y,
  input  logic [10:0] cmd_data,
  output logic [9:0]  ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_we,
  input  logic [31:0] ram_rdata,
  output logic        done,
  output logic        err,
  output state_e      dbg_state_o
);

  localparam logic [9:0] LAST_ADDR = 10'(COLS * ROWS - 1);

`ifdef TILE_STATE_WRITER_INIT_CLEAR_EN
  localparam state_e RESET_STATE = ST_CLR;
`else
  localparam state_e RESET_STATE = ST_IDLE;
`endif

  state_e      state_q;
  cmd_op_e     op_q;
  logic [10:0] data_q;
  logic [9:0]  ram_addr_q;
  logic [31:0] ram_wdata_q;
  logic        ram_we_q;
  logic        cmd_ready_q;
  logic        done_q;
  logic        err_q;

  logic [9:0]  addr_d;
  logic        in_range_d;
  cmd_op_e     op_d;

  assign op_d = cmd_op_e'(cmd_op);

  tile_addr_calc #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_addr_calc (
    .x_i        (cmd_x),
    .y_i        (cmd_y),
    .addr_o     (addr_d),
    .in_range_o (in_range_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      op_q        <= OP_SET_SPR1;
      data_q      <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // The first IDLE cycle after reset has cmd_ready low, so nothing is taken then.
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            op_q   <= op_d;
            data_q <= cmd_data;
            if (op_d == OP_CLEAR) begin
              state_q     <= ST_CLR;
              ram_addr_q  <= '0;
              ram_wdata_q <= CLEAR_WORD;
              ram_we_q    <= 1'b1;
              cmd_ready_q <= 1'b0;
            end else if (in_range_d) begin
              state_q     <= ST_RD;
              ram_addr_q  <= addr_d;
              cmd_ready_q <= 1'b0;
            end else begin
              // Dropped command: stay in IDLE, ready remains high.
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end
          end
        end
        ST_RD: begin
          state_q <= ST_MOD;
        end
        ST_MOD: begin
          ram_wdata_q <= merge_field(op_q, ram_rdata, data_q);
          ram_we_q    <= 1'b1;
          state_q     <= ST_WR;
        end
        ST_WR: begin
          ram_we_q    <= 1'b0;
          done_q      <= 1'b1;
          cmd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        ST_CLR: begin
          if (!ram_we_q) begin
            // A sweep entered directly from reset starts here with write enable still low.
            ram_we_q    <= 1'b1;
            ram_addr_q  <= '0;
            ram_wdata_q <= CLEAR_WORD;
          end else if (ram_addr_q == LAST_ADDR) begin
            ram_we_q    <= 1'b0;
            done_q      <= 1'b1;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            ram_addr_q <= ram_addr_q + 10'd1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          ram_we_q    <= 1'b0;
          cmd_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign ram_we      = ram_we_q;
  assign done        = done_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tile_state_writer.sv
// Bench for tile_state_writer.
// A timeline model turns each accepted command into the per-cycle outputs it must
// produce; a reference memory tracks what the state RAM should hold.
module tb_tile_state_writer;

  typedef struct {
    logic        ready;
    logic        we;
    logic        done;
    logic        err;
    logic        chk_addr;
    logic [9:0]  addr;
    logic [31:0] wdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [4:0]  cmd_x = 5'd0;
  logic [4:0]  cmd_y = 5'd0;
  logic [10:0] cmd_data = 11'd0;
  logic        cmd_ready;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata = 32'd0;
  logic        done;
  logic        err;
  tile_state_pkg::state_e dbg_state;

  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  exp_t        exp_q[$];
  exp_t        cur_e;
  int          we_rise[$];

  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   we_count = 0;
  int   err_count = 0;
  logic rst_seen = 1'b0;
  logic pending_release = 1'b0;
  logic prev_we = 1'b0;
  logic [31:0] last_wdata = 32'd0;
  logic [9:0]  last_waddr = 10'd0;

  tile_state_writer dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_data    (cmd_data),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_we      (ram_we),
    .ram_rdata   (ram_rdata),
    .done        (done),
    .err         (err),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset sampling
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  // State RAM: one-cycle read latency, read-before-write
  always @(posedge clk) begin
    logic [31:0] rd;
    rd = mem[ram_addr];
    if (ram_we) mem[ram_addr] = ram_wdata;
    ram_rdata <= rd;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_e(input logic rdy, input logic we, input logic dn, input logic er,
                        input logic ca, input logic [9:0] a, input logic [31:0] wd);
    exp_t e;
    e.ready = rdy; e.we = we; e.done = dn; e.err = er;
    e.chk_addr = ca; e.addr = a; e.wdata = wd;
    exp_q.push_back(e);
  endtask

  task automatic push_clear();
    for (int i = 0; i < 416; i++) push_e(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'(i), 32'd0);
    push_e(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 32'd0);
  endtask

  // Model: what the outputs must be in the cycles after an accepted command
  task automatic schedule(input logic [1:0] op, input logic [4:0] x, input logic [4:0] y,
                          input logic [10:0] d);
    int          a;
    logic [31:0] old_w;
    logic [31:0] new_w;
    logic [31:0] dx;
    a  = int'(y) * 26 + int'(x);
    dx = {21'd0, d};
    if (op == 2'b11) begin
      push_clear();
    end else if (x >= 5'd26 || y >= 5'd16) begin
      push_e(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 32'd0);
    end else begin
      old_w = ref_mem[10'(a)];
      case (op)
        2'b00:   new_w = (old_w & ~(32'h7FF << 10)) | (dx << 10);
        2'b01:   new_w = (old_w & 32'h001F_FFFF) | (dx << 21);
        default: new_w = (old_w & ~32'h3FF) | (dx & 32'h3FF);
      endcase
      push_e(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'(a), 32'd0);
      push_e(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'(a), 32'd0);
      push_e(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'(a), new_w);
      push_e(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 32'd0);
    end
  endtask

  // Scoreboard compare: every cycle, on the falling edge
  always @(negedge clk) begin
    if (rst_seen) begin
      exp_q.delete();
      pending_release = 1'b1;
      prev_we = 1'b0;
      check("rst_ready", 32'(cmd_ready), 32'd0);
      check("rst_we",    32'(ram_we),    32'd0);
      check("rst_done",  32'(done),      32'd0);
      check("rst_err",   32'(err),       32'd0);
      check("rst_addr",  32'(ram_addr),  32'd0);
      check("rst_wdata", ram_wdata,      32'd0);
    end else begin
      if (pending_release) begin
        pending_release = 1'b0;
`ifdef TILE_STATE_WRITER_INIT_CLEAR_EN
        push_clear();
`endif
      end
      if (exp_q.size() > 0) cur_e = exp_q.pop_front();
      else begin
        cur_e.ready = 1'b1; cur_e.we = 1'b0; cur_e.done = 1'b0; cur_e.err = 1'b0;
        cur_e.chk_addr = 1'b0; cur_e.addr = 10'd0; cur_e.wdata = 32'd0;
      end
      check("cmd_ready", 32'(cmd_ready), 32'(cur_e.ready));
      check("ram_we",    32'(ram_we),    32'(cur_e.we));
      check("done",      32'(done),      32'(cur_e.done));
      check("err",       32'(err),       32'(cur_e.err));
      if (cur_e.we || cur_e.chk_addr) check("ram_addr", 32'(ram_addr), 32'(cur_e.addr));
      if (cur_e.we) begin
        check("ram_wdata", ram_wdata, cur_e.wdata);
        ref_mem[cur_e.addr] = cur_e.wdata;
      end
      if (ram_we) begin
        we_count++;
        last_wdata = ram_wdata;
        last_waddr = ram_addr;
        if (!prev_we) we_rise.push_back(cyc);
      end
      prev_we = ram_we;
      if (err) err_count++;
      if (cmd_valid && cur_e.ready) schedule(cmd_op, cmd_x, cmd_y, cmd_data);
    end
  end

  // Driver tasks
  task automatic preload(input int a, input logic [31:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic send(input logic [1:0] op, input int x, input int y, input logic [10:0] d,
                      input bit hold, output int acc);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_x = 5'(x); cmd_y = 5'(y); cmd_data = d;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
    end
    acc = cyc;
    if (!ok) begin
      check("send_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      if (!hold) cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && !pending_release) begin ok = 1'b1; break; end
    end
    #1;
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2, acc;
    int we0, er0;
    bit found;
    for (int i = 0; i < 1024; i++) begin mem[i] = 32'd0; ref_mem[i] = 32'd0; end

    // Reset
    @(posedge clk); #1;
    check("lit_rst_we", 32'(ram_we), 32'd0);
    check("lit_rst_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    wait_idle();
`ifdef TILE_STATE_WRITER_INIT_CLEAR_EN
    check("lit_init_sweep_words", 32'(we_count), 32'd416);
`endif

    // Sprite1 update at (3,2)
    preload(55, 32'hFFE0_0000);
    send(2'b00, 3, 2, 11'h005, 1'b0, acc);
    wait_idle();
    check("lit_spr1_addr", 32'(last_waddr), 32'd55);
    check("lit_spr1_wdata", last_wdata, 32'hFFE0_1400);
    check("lit_spr1_mem", mem[55], 32'hFFE0_1400);

    // Sprite2 update at the last tile
    preload(415, 32'h0000_03FF);
    send(2'b01, 25, 15, 11'h7FF, 1'b0, acc);
    wait_idle();
    check("lit_spr2_addr", 32'(last_waddr), 32'd415);
    check("lit_spr2_mem", mem[415], 32'hFFE0_03FF);

    // Flags update, data[10] ignored
    preload(0, 32'h1234_5678);
    send(2'b10, 0, 0, 11'h6AB, 1'b0, acc);
    wait_idle();
    check("lit_flags_mem", mem[0], 32'h1234_56AB);

    // Out-of-range x and y
    we0 = we_count; er0 = err_count;
    send(2'b00, 26, 0, 11'h001, 1'b0, acc);
    wait_idle();
    send(2'b01, 0, 16, 11'h001, 1'b0, acc);
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    check("lit_oor_no_we", 32'(we_count - we0), 32'd0);
    check("lit_oor_err_pulses", 32'(err_count - er0), 32'd2);

    // Two queued updates with cmd_valid held high
    preload(27, 32'hAAAA_AAAA);
    preload(28, 32'h5555_5555);
    send(2'b00, 1, 1, 11'h3FF, 1'b1, acc1);
    send(2'b10, 2, 1, 11'h001, 1'b0, acc2);
    wait_idle();
    check("lit_b2b_accept_gap", 32'(acc2 - acc1), 32'd4);
    check("lit_b2b_we_at_n7", 32'(we_rise[$] - acc1), 32'd7);
    check("lit_b2b_mem27", mem[27], 32'hAAAF_FEAA);
    check("lit_b2b_mem28", mem[28], 32'h5555_5401);

    // Full clear
    we0 = we_count;
    send(2'b11, 31, 31, 11'h7FF, 1'b0, acc);
    wait_idle();
    check("lit_clr_words", 32'(we_count - we0), 32'd416);
    check("lit_clr_mem415", mem[415], 32'd0);
    check("lit_clr_mem27", mem[27], 32'd0);

    // Clear interrupted by reset at address 100
    preload(101, 32'h1111_1111);
    preload(200, 32'hDEAD_BEEF);
    send(2'b11, 0, 0, 11'h000, 1'b0, acc);
    found = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (ram_we === 1'b1 && ram_addr === 10'd100) begin found = 1'b1; break; end
    end
    if (!found) check("sweep_addr100_timeout", 32'd0, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("lit_midsweep_rst_we", 32'(ram_we), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    wait_idle();
`ifdef TILE_STATE_WRITER_INIT_CLEAR_EN
    check("lit_resweep_mem101", mem[101], 32'd0);
    check("lit_resweep_mem200", mem[200], 32'd0);
`else
    check("lit_abort_mem101", mem[101], 32'h1111_1111);
    check("lit_abort_mem200", mem[200], 32'hDEAD_BEEF);
`endif

    // Operation resumes after the interrupted sweep
    send(2'b01, 0, 1, 11'h001, 1'b0, acc);
    wait_idle();
    check("lit_resume_mem26", mem[26], 32'h0020_0000);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tile_state_writer.md
# tile_state_writer

Write-side engine for the tile state RAM that the sprite renderer scans every frame. It accepts tile update commands from game logic over a valid/ready handshake. Each update is a read-modify-write of one packed 32-bit tile word, changing one field and preserving the others. It also sweeps the whole 26x16 board to a clear word on command. It owns the second port of the dual-port state RAM; the renderer owns the read-only port.

## Interface
Parameters:
- COLS, 26, tiles per row (address stride)
- ROWS, 16, tile rows (416 words used)
- CLEAR_WORD, 32'h0000_0000, value written by a clear sweep

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  00 set sprite1 [20:10], 01 set sprite2 [31:21], 10 set flags [9:0], 11 clear board
- cmd_x  in  5  tile column
- cmd_y  in  5  tile row
- cmd_data  in  11  new field value; op 10 uses [9:0]; ignored for op 11
- ram_addr  out  10  state RAM address
- ram_wdata  out  32  state RAM write data
- ram_we  out  1  state RAM write enable
- ram_rdata  in  32  state RAM read data, 1-cycle synchronous latency
- done  out  1  one-cycle pulse when a command retires
- err  out  1  one-cycle pulse when a command is dropped for being out of range

## Operation
- Address: addr = cmd_y*COLS + cmd_x, computed in 10 bits.
- Range check: a command with cmd_x >= COLS or cmd_y >= ROWS is accepted and then dropped:
  - no RAM access;
  - err and done pulse together in the next cycle;
  - the FSM returns to IDLE.
- Range check is skipped for op 11.
- FSM states: IDLE, RD, MOD, WR, CLR.
- IDLE:
  - cmd_ready=1.
  - On accept, latch op and data, and register ram_addr.
  - Valid update → RD. Clear → CLR. Out of range → IDLE with err/done pulse.
- RD: ram_addr is held; the RAM samples it at the end of this cycle.
- MOD:
  - ram_rdata is valid.
  - Register ram_wdata = ram_rdata with only the selected field replaced.
  - Drive ram_we<=1 and go to WR.
- WR: ram_we=1 for exactly this cycle, then ram_we<=0, done pulse, → IDLE.
- CLR:
  - ram_we=1 with ram_wdata=CLEAR_WORD, ram_addr counting 0..COLS*ROWS-1, one word per cycle.
  - After the last word: ram_we<=0, done pulse, → IDLE.
- cmd_ready is 0 in every state except IDLE. Commands are strictly serialised, so there is no RMW hazard.

## Timing
- Reset values: cmd_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, done=0, err=0. The FSM state after reset is set by the macro.
- Update latency (n = accept edge):
  - n+1 RD, n+2 MOD, n+3 WR (ram_we=1);
  - n+4 IDLE with done=1 and cmd_ready=1;
  - throughput is one update per 4 cycles.
- Out-of-range: cycle n+1 has err=done=cmd_ready=1.
- Clear: 416 consecutive ram_we cycles starting at n+1. done and cmd_ready are 1 at n+417.
- Reset asserted in any state, including mid-sweep or in WR: ram_we is 0 at the next edge, and any in-flight command is discarded without a partial write.

## Configuration
- TILE_STATE_WRITER_INIT_CLEAR_EN
  - Defined: leaving reset enters CLR and sweeps all 416 words to CLEAR_WORD. cmd_ready stays 0 until the sweep's done pulse.
  - Undefined: leaving reset enters IDLE. RAM contents are left untouched (preloaded by init file).

## Structure
- Package tile_state_pkg holds:
  - COLS and ROWS;
  - field LSB/MSB constants (SPR1 20:10, SPR2 31:21, FLAGS 9:0);
  - the cmd_op enum;
  - the FSM state enum.
- The renderer imports the same field constants.
- One sub-module, tile_addr_calc: combinational x,y → addr plus in_range flag. It is shared with the game-logic collision lookups.

## Test plan
- Reset with macro defined:
  - ram_we is high for 416 cycles, ram_addr runs 0..415, wdata=0, cmd_ready=0;
  - then done=1 and cmd_ready=1.
- Op 00, x=3, y=2, data=11'h005, RAM word 0xFFE0_0000: ram_addr=55, and at n+3 ram_we=1 with ram_wdata=0xFFE0_1400.
- Op 01, x=25, y=15, data=11'h7FF, RAM word 0x0000_03FF: ram_addr=415, and ram_wdata=0xFFE0_03FF.
- Op 00, x=26, y=0: no ram_we; at n+1 err=done=1; at n+2 err=0.
- cmd_valid held high with two queued updates: the second is accepted at n+4, and its ram_we lands at n+7.
- Reset pulsed while the clear sweep is at addr 100: ram_we=0 the next cycle. With the macro defined, the sweep restarts at addr 0.
